mu0_mem_responder: RTL

MU0_MEM_RESPONDER -- requirements
Module: mu0_mem_responder

---
 rtl/mu0_mem_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mu0_mem_responder.sv
// MU0 word-addressed memory with a fixed number of wait states per access.
// Request fields are captured on acceptance; ack pulses for one cycle.
module mu0_mem_responder #(
    parameter int MAXWIDTH    = 16,
    parameter int MAXDEPTH    = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [MAXDEPTH-1:0] Abus,
    input  logic [MAXWIDTH-1:0] Wdata,
    input  logic                req,
    input  logic                wr,
    output logic [MAXWIDTH-1:0] Dbus,
    output logic                ack,
    output logic                busy
);

    localparam int       WORDS     = 2 ** MAXDEPTH;
    localparam bit       ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_INIT =
        ZERO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [3:0]          cnt;
    logic [3:0]          cnt_n;
    logic [MAXDEPTH-1:0] addr_q;
    logic                wr_q;
    logic [MAXWIDTH-1:0] data_q;
    logic                load;
    logic                commit;
    logic [MAXDEPTH-1:0] acc_addr;
    logic                acc_wr;
    logic [MAXWIDTH-1:0] acc_data;

    logic [MAXWIDTH-1:0] mem [WORDS];

    // With zero wait states the commit edge is the capture edge,
    // so the access fields come straight from the inputs.
    always_comb begin
        acc_addr = addr_q;
        acc_wr   = wr_q;
        acc_data = data_q;
        if (state == IDLE) begin
            acc_addr = Abus;
            acc_wr   = wr;
            acc_data = Wdata;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        commit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    load = 1'b1;
                    if (ZERO_WAIT) begin
                        state_n = ACK;
                        commit  = 1'b1;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_n = ACK;
                    commit  = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            ACK: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            wr_q   <= 1'b0;
            data_q <= '0;
            Dbus   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (load) begin
                addr_q <= Abus;
                wr_q   <= wr;
                data_q <= Wdata;
            end
            if (commit && !acc_wr) begin
                Dbus <= mem[acc_addr];
            end
        end
    end

    // Array contents survive reset; an aborted write never commits.
    always_ff @(posedge clk) begin
        if (!reset && commit && acc_wr) begin
            mem[acc_addr] <= acc_data;
        end
    end

    assign ack  = (state == ACK);
    assign busy = (state != IDLE);

endmodule
